ca_code_sequencer: RTL and testbench
====================================

// Module: ca_code_sequencer
// PURPOSE
//  Sequences one CA code generator for a tracking channel. It loads the PRN and
//  holds the generator in reset, then fast-slews to a requested initial code phase.
//  After that it advances one chip per chip-rate strobe from the code NCO.
//  Advance/retard slew requests from the tracking loop are applied by inserting
//  or swallowing chip advances. Also reports code phase and the 1 ms code epoch.
// PARAMETERS
//  CODE_LEN  1023  chips per code period; code_phase wraps CODE_LEN-1 -> 0
//  PHASE_W   10    width of code_phase, init_phase and slew_amt
// PORTS
//  clock       in   1        system clock
//  reset       in   1        synchronous, active-high
//  start       in   1        pulse: latch prn/init_phase, (re)start the channel
//  stop        in   1        pulse: return to IDLE; has priority over start
//  prn         in   5        PRN select, sampled on start
//  init_phase  in   PHASE_W  target phase after load; values >= CODE_LEN are treated as 0
//  chip_tick   in   1        one-cycle chip-rate strobe from code NCO
//  slew_req    in   1        slew request, honoured only in TRACK with no slew pending
//  slew_dir    in   1        1 = advance (insert chips), 0 = retard (swallow ticks)
//  slew_amt    in   PHASE_W  chips to slew
//  slew_ack    out  1        one-cycle pulse, cycle after an accepted slew_req
//  slew_busy   out  1        high while a slew count is nonzero
//  gen_reset   out  1        drives generator reset (generator -> all-ones, phase 0)
//  gen_advance out  1        generator clock enable: one chip per asserted cycle
//  gen_prn     out  5        PRN to generator
//  code_phase  out  PHASE_W  count of gen_advance pulses since LOAD, mod CODE_LEN
//  epoch       out  1        gen_advance & (code_phase == CODE_LEN-1)
//  state       out  2        0 IDLE, 1 LOAD, 2 SEEK, 3 TRACK
// BEHAVIOUR
//  - All outputs are registered except epoch, which is an AND of registered signals.
//  - Reset values: state IDLE, gen_reset 1, gen_advance 0, gen_prn 5'd1,
//    code_phase 0, slew_ack 0, slew_busy 0, epoch 0. All slew counters cleared.
//  - code_phase increments on every edge that ends a cycle with gen_advance=1.
//    It wraps CODE_LEN-1 -> 0, and epoch is high in that same cycle.
//  - IDLE: gen_reset=1, gen_advance=0. start -> LOAD; prn is latched to gen_prn.
//  - LOAD: exactly one cycle; gen_reset=1, code_phase cleared to 0.
//    Next state is SEEK if the target is nonzero, else TRACK.
//  - SEEK: gen_reset=0, gen_advance=1 every cycle. chip_tick is ignored.
//    Stays in SEEK for exactly `target` cycles, then enters TRACK with
//    code_phase == target.
//  - TRACK, normal: gen_advance is asserted the cycle after each chip_tick
//    (one-cycle latency).
//  - TRACK, advance slew: one extra gen_advance is inserted on each cycle in which
//    no tick-driven advance occurs, until the slew count reaches 0.
//    Maximum one advance per cycle; a tick-driven advance wins over a slew insertion.
//  - TRACK, retard slew: each chip_tick is swallowed (no gen_advance) and the slew
//    count decrements, until the count reaches 0.
//  - Slew request rules:
//    - slew_req with slew_amt=0 is acked and has no effect.
//    - slew_req while slew_busy, or outside TRACK, is dropped (no ack).
//  - start in LOAD, SEEK or TRACK restarts the channel: next state LOAD with the new
//    prn/init_phase; any pending slew is discarded.
//  - stop in any state: next state IDLE, slew cleared, gen_advance=0 next cycle.
//  - Simultaneous stop and start: stop wins.
//  - reset mid-operation gives the reset values above on the next edge, in any state.
// TESTING
//  1. reset, start prn=1 init_phase=0 -> LOAD 1 cycle, then TRACK. 1023 ticks ->
//     1023 gen_advance pulses, one epoch on the 1023rd, code_phase back at 0.
//  2. start init_phase=5 -> exactly 5 consecutive gen_advance cycles in SEEK,
//     then TRACK with code_phase=5. init_phase=1023 -> behaves as 0.
//  3. TRACK, tick every 4 cycles, slew_req dir=1 amt=3 -> slew_ack next cycle;
//     3 extra advances in non-tick cycles; code_phase ahead by 3.
//  4. TRACK, slew_req dir=0 amt=2 -> next 2 ticks produce no gen_advance,
//     slew_busy drops after the 2nd; a second slew_req while busy is not acked.
//  5. Tick every cycle with advance slew pending -> slew stalls, code_phase +1/cycle.
//     Tick gap -> slew completes.
//  6. Mid-SEEK start prn=7 -> LOAD, gen_prn=7, code_phase=0.
//     stop+start together -> IDLE. reset mid-TRACK -> all reset values.

Source files
------------

// File: rtl/ca_code_sequencer.sv
// Tracking-channel sequencer for one CA code generator: PRN load, fast seek to the
// initial code phase, chip-rate tracking with advance/retard slew, phase and epoch report.
module ca_code_sequencer #(
    parameter int unsigned CODE_LEN = 1023,
    parameter int unsigned PHASE_W  = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [4:0]         prn,
    input  logic [PHASE_W-1:0] init_phase,
    input  logic               chip_tick,
    input  logic               slew_req,
    input  logic               slew_dir,
    input  logic [PHASE_W-1:0] slew_amt,
    output logic               slew_ack,
    output logic               slew_busy,
    output logic               gen_reset,
    output logic               gen_advance,
    output logic [4:0]         gen_prn,
    output logic [PHASE_W-1:0] code_phase,
    output logic               epoch,
    output logic [1:0]         state
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CODE_LEN - 1);
    localparam logic [PHASE_W-1:0] LEN_PHASE  = PHASE_W'(CODE_LEN);
    localparam logic [PHASE_W-1:0] ONE        = PHASE_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEEK  = 2'd2,
        TRACK = 2'd3
    } state_t;

    state_t             st, st_nx;
    logic [PHASE_W-1:0] target, target_nx;
    logic [PHASE_W-1:0] seek_cnt, seek_cnt_nx;
    logic [PHASE_W-1:0] slew_cnt, slew_cnt_nx;
    logic [PHASE_W-1:0] code_phase_nx;
    logic               slew_adv, slew_adv_nx;
    logic               gen_advance_nx;
    logic               slew_ack_nx;
    logic [4:0]         gen_prn_nx;

    assign state = st;
    assign epoch = gen_advance & (code_phase == LAST_PHASE);

    always_ff @(posedge clock) begin
        if (reset) begin
            st          <= IDLE;
            target      <= '0;
            seek_cnt    <= '0;
            slew_cnt    <= '0;
            slew_adv    <= 1'b0;
            code_phase  <= '0;
            gen_reset   <= 1'b1;
            gen_advance <= 1'b0;
            gen_prn     <= 5'd1;
            slew_ack    <= 1'b0;
            slew_busy   <= 1'b0;
        end else begin
            st          <= st_nx;
            target      <= target_nx;
            seek_cnt    <= seek_cnt_nx;
            slew_cnt    <= slew_cnt_nx;
            slew_adv    <= slew_adv_nx;
            code_phase  <= code_phase_nx;
            gen_reset   <= (st_nx == IDLE) || (st_nx == LOAD);
            gen_advance <= gen_advance_nx;
            gen_prn     <= gen_prn_nx;
            slew_ack    <= slew_ack_nx;
            slew_busy   <= (slew_cnt_nx != '0);
        end
    end

    always_comb begin
        st_nx          = st;
        target_nx      = target;
        seek_cnt_nx    = seek_cnt;
        slew_cnt_nx    = slew_cnt;
        slew_adv_nx    = slew_adv;
        gen_advance_nx = 1'b0;
        slew_ack_nx    = 1'b0;
        gen_prn_nx     = gen_prn;
        code_phase_nx  = code_phase;
        if (gen_advance) begin
            code_phase_nx = (code_phase == LAST_PHASE) ? '0 : code_phase + ONE;
        end

        if (stop) begin
            st_nx       = IDLE;
            slew_cnt_nx = '0;
        end else if (start) begin
            st_nx         = LOAD;
            gen_prn_nx    = prn;
            target_nx     = (init_phase >= LEN_PHASE) ? '0 : init_phase;
            slew_cnt_nx   = '0;
            code_phase_nx = '0;
        end else begin
            case (st)
                IDLE: ;
                LOAD: begin
                    if (target != '0) begin
                        st_nx          = SEEK;
                        seek_cnt_nx    = target;
                        gen_advance_nx = 1'b1;
                    end else begin
                        st_nx = TRACK;
                    end
                end
                SEEK: begin
                    seek_cnt_nx = seek_cnt - ONE;
                    if (seek_cnt == ONE) begin
                        st_nx = TRACK;
                    end else begin
                        gen_advance_nx = 1'b1;
                    end
                end
                TRACK: begin
                    // Advance slew fills every non-tick cycle; retard slew eats ticks
                    if (slew_cnt != '0) begin
                        if (slew_adv) begin
                            gen_advance_nx = 1'b1;
                            if (!chip_tick) slew_cnt_nx = slew_cnt - ONE;
                        end else if (chip_tick) begin
                            slew_cnt_nx = slew_cnt - ONE;
                        end
                    end else begin
                        gen_advance_nx = chip_tick;
                        if (slew_req) begin
                            slew_ack_nx = 1'b1;
                            slew_cnt_nx = slew_amt;
                            slew_adv_nx = slew_dir;
                        end
                    end
                end
                default: st_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_code_sequencer.sv
// Bench for ca_code_sequencer: cycle model of the channel rules checked every cycle,
// plus directed scenarios with hand-computed phase/pulse counts.
module tb_ca_code_sequencer;

    localparam int CODE_LEN = 1023;
    localparam int PHASE_W  = 10;

    logic               clock = 1'b0;
    logic               reset, start, stop, chip_tick, slew_req, slew_dir;
    logic [4:0]         prn;
    logic [PHASE_W-1:0] init_phase, slew_amt;
    logic               slew_ack, slew_busy, gen_reset, gen_advance, epoch;
    logic [4:0]         gen_prn;
    logic [PHASE_W-1:0] code_phase;
    logic [1:0]         state;

    int checks = 0;
    int errors = 0;
    int adv_cnt = 0;
    int ep_cnt = 0;

    ca_code_sequencer #(.CODE_LEN(CODE_LEN), .PHASE_W(PHASE_W)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .prn(prn),
        .init_phase(init_phase), .chip_tick(chip_tick), .slew_req(slew_req),
        .slew_dir(slew_dir), .slew_amt(slew_amt), .slew_ack(slew_ack),
        .slew_busy(slew_busy), .gen_reset(gen_reset), .gen_advance(gen_advance),
        .gen_prn(gen_prn), .code_phase(code_phase), .epoch(epoch), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the channel: phase = advances since LOAD mod CODE_LEN, remaining seek/slew counts
    bit m_valid = 0;
    int m_state, m_phase, m_prn, m_target, m_seek, m_slew;
    bit m_adv, m_greset, m_ack, m_busy, m_slew_dir;

    always @(posedge clock) begin
        int  nphase, nstate;
        bit  nadv;
        if (reset) begin
            m_valid = 1; m_state = 0; m_phase = 0; m_prn = 1; m_target = 0;
            m_seek = 0; m_slew = 0; m_adv = 0; m_greset = 1; m_ack = 0;
            m_busy = 0; m_slew_dir = 0;
        end else if (m_valid) begin
            nphase = m_adv ? (m_phase + 1) % CODE_LEN : m_phase;
            nstate = m_state;
            nadv   = 0;
            m_ack  = 0;
            if (stop) begin
                nstate = 0; m_slew = 0;
            end else if (start) begin
                nstate = 1; m_prn = int'(prn); m_slew = 0; nphase = 0;
                m_target = (int'(init_phase) >= CODE_LEN) ? 0 : int'(init_phase);
            end else if (m_state == 1) begin
                if (m_target > 0) begin nstate = 2; m_seek = m_target; end
                else nstate = 3;
            end else if (m_state == 2) begin
                m_seek = m_seek - 1;
                if (m_seek == 0) nstate = 3;
            end else if (m_state == 3) begin
                if (m_slew > 0 && m_slew_dir) begin
                    nadv = 1;
                    if (!chip_tick) m_slew = m_slew - 1;
                end else if (m_slew > 0) begin
                    if (chip_tick) m_slew = m_slew - 1;
                end else begin
                    nadv = chip_tick;
                    if (slew_req) begin
                        m_ack = 1; m_slew = int'(slew_amt); m_slew_dir = slew_dir;
                    end
                end
            end
            if (nstate == 2) nadv = 1;
            m_state = nstate; m_phase = nphase; m_adv = nadv;
            m_greset = (nstate <= 1); m_busy = (m_slew > 0);
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("state", 32'(state), 32'(m_state));
            check("code_phase", 32'(code_phase), 32'(m_phase));
            check("gen_advance", 32'(gen_advance), 32'(m_adv));
            check("gen_reset", 32'(gen_reset), 32'(m_greset));
            check("gen_prn", 32'(gen_prn), 32'(m_prn));
            check("slew_ack", 32'(slew_ack), 32'(m_ack));
            check("slew_busy", 32'(slew_busy), 32'(m_busy));
            check("epoch", 32'(epoch), 32'(m_adv && m_phase == CODE_LEN - 1));
            if (gen_advance === 1'b1) adv_cnt++;
            if (epoch === 1'b1) ep_cnt++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_group(input int idle);
        chip_tick = 1'b1;
        step();
        chip_tick = 1'b0;
        repeat (idle) step();
    endtask

    task automatic do_start(input logic [4:0] p, input logic [PHASE_W-1:0] ph);
        prn = p; init_phase = ph; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; chip_tick = 1'b0;
        slew_req = 1'b0; slew_dir = 1'b0; slew_amt = '0; prn = 5'd0; init_phase = '0;
        repeat (2) step();
        check("reset_state", 32'(state), 32'd0);
        check("reset_prn", 32'(gen_prn), 32'd1);
        check("reset_gen_reset", 32'(gen_reset), 32'd1);
        reset = 1'b0;
        step();

        // 1: full code period from phase 0
        do_start(5'd1, 10'd0);
        check("t1_load", 32'(state), 32'd1);
        step();
        check("t1_track", 32'(state), 32'd3);
        adv_cnt = 0; ep_cnt = 0;
        for (int i = 0; i < 1023; i++) tick_group(1);
        step();
        check("t1_adv_count", 32'(adv_cnt), 32'd1023);
        check("t1_epoch_count", 32'(ep_cnt), 32'd1);
        check("t1_phase_wrap", 32'(code_phase), 32'd0);

        // 2: seek to 5, then out-of-range init phase
        adv_cnt = 0;
        do_start(5'd2, 10'd5);
        repeat (8) step();
        check("t2_seek_advances", 32'(adv_cnt), 32'd5);
        check("t2_phase", 32'(code_phase), 32'd5);
        check("t2_state", 32'(state), 32'd3);
        do_start(5'd2, 10'd1023);
        step();
        check("t2_1023_track", 32'(state), 32'd3);
        check("t2_1023_phase", 32'(code_phase), 32'd0);

        // 3: advance slew of 3 with a tick every 4 cycles
        chip_tick = 1'b1; step(); chip_tick = 1'b0;
        slew_req = 1'b1; slew_dir = 1'b1; slew_amt = 10'd3;
        step();
        slew_req = 1'b0;
        check("t3_ack", 32'(slew_ack), 32'd1);
        repeat (2) step();
        repeat (4) tick_group(3);
        step();
        check("t3_phase", 32'(code_phase), 32'd8);
        check("t3_idle_busy", 32'(slew_busy), 32'd0);

        // 4: retard slew of 2, second request while busy is dropped
        slew_req = 1'b1; slew_dir = 1'b0; slew_amt = 10'd2;
        step();
        slew_req = 1'b0;
        check("t4_ack", 32'(slew_ack), 32'd1);
        check("t4_busy", 32'(slew_busy), 32'd1);
        chip_tick = 1'b1; step(); chip_tick = 1'b0;
        check("t4_busy_after1", 32'(slew_busy), 32'd1);
        step();
        slew_req = 1'b1; slew_dir = 1'b1; slew_amt = 10'd5;
        step();
        slew_req = 1'b0;
        check("t4_busy_no_ack", 32'(slew_ack), 32'd0);
        step();
        chip_tick = 1'b1; step(); chip_tick = 1'b0;
        check("t4_busy_after2", 32'(slew_busy), 32'd0);
        repeat (3) step();
        repeat (2) tick_group(3);
        step();
        check("t4_phase", 32'(code_phase), 32'd10);

        // 5: advance slew stalled by back-to-back ticks, then completes in the gap
        slew_req = 1'b1; slew_dir = 1'b1; slew_amt = 10'd3;
        step();
        slew_req = 1'b0;
        chip_tick = 1'b1;
        repeat (6) step();
        chip_tick = 1'b0;
        check("t5_stalled_busy", 32'(slew_busy), 32'd1);
        check("t5_stalled_phase", 32'(code_phase), 32'd15);
        repeat (5) step();
        check("t5_busy_done", 32'(slew_busy), 32'd0);
        check("t5_phase", 32'(code_phase), 32'd19);

        // 6: restart mid-seek, stop beats start, reset mid-track
        do_start(5'd7, 10'd100);
        repeat (10) step();
        do_start(5'd7, 10'd50);
        check("t6_restart_state", 32'(state), 32'd1);
        check("t6_restart_prn", 32'(gen_prn), 32'd7);
        check("t6_restart_phase", 32'(code_phase), 32'd0);
        stop = 1'b1; start = 1'b1; prn = 5'd3;
        step();
        stop = 1'b0; start = 1'b0;
        check("t6_stop_wins", 32'(state), 32'd0);
        check("t6_stop_prn_kept", 32'(gen_prn), 32'd7);
        do_start(5'd3, 10'd0);
        step();
        slew_req = 1'b1; slew_dir = 1'b1; slew_amt = 10'd10;
        step();
        slew_req = 1'b0;
        repeat (3) step();
        check("t6_pre_reset_phase", 32'(code_phase), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_reset_state", 32'(state), 32'd0);
        check("t6_reset_prn", 32'(gen_prn), 32'd1);
        check("t6_reset_phase", 32'(code_phase), 32'd0);
        check("t6_reset_busy", 32'(slew_busy), 32'd0);
        check("t6_reset_adv", 32'(gen_advance), 32'd0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
